// File: rtl/bist_engine.sv
// Built-in self-test sequencer: drives an external arithmetic unit in normal or LFSR test mode
// and compresses its results into a bit-serial CRC signature compared against a golden value.
module bist_engine #(
   parameter int                 W         = 8,
   parameter int                 RW        = 12,
   parameter int                 SIG_W     = 8,
   parameter int                 ITER      = 256,
   parameter logic [W-1:0]       LFSR_POLY = 8'hB8,
   parameter logic [SIG_W-1:0]   CRC_POLY  = 8'h07,
   parameter int                 TIMEOUT   = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_tgl,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [SIG_W-1:0] golden,
   output logic             dut_rst,
   output logic             dut_start,
   output logic [W-1:0]     dut_a,
   output logic [W-1:0]     dut_b,
   input  logic [RW-1:0]    dut_y,
   input  logic             dut_ready,
   output logic [RW-1:0]    result,
   output logic [SIG_W-1:0] sig,
   output logic [7:0]       run_cnt,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic             timeout
);

   localparam int          BW        = $clog2(RW + 1);
   localparam int          WDW       = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(RW - 1);
   localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
   localparam logic [15:0]    ITER_LAST = 16'(ITER - 1);

   typedef enum logic [3:0] {
      IDLE, N_LOAD, N_WAIT, N_OUT, T_INIT, T_STEP, T_LOAD, T_WAIT, T_SHIFT, T_NEXT, T_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             tmode_q, tmode_d;
   logic             dut_rst_q, dut_rst_d;
   logic             dut_start_q, dut_start_d;
   logic [W-1:0]     dut_a_q, dut_a_d, dut_b_q, dut_b_d;
   logic [RW-1:0]    result_q, result_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [7:0]       run_cnt_q, run_cnt_d;
   logic             pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
   logic [W-1:0]     lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d;
   logic [SIG_W-1:0] crc_q, crc_d;
   logic [15:0]      iter_q, iter_d;
   logic [BW-1:0]    bidx_q, bidx_d;
   logic [WDW-1:0]   wd_q, wd_d;
   logic [RW-1:0]    y_q, y_d;
   logic             done_ent_q, done_ent_d;
   logic             pass_now;
   logic             rdy_ok;

   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] r);
      return (r >> 1) ^ (r[0] ? LFSR_POLY : '0);
   endfunction

   function automatic logic [SIG_W-1:0] crc_step(input logic [SIG_W-1:0] c, input logic bit_i);
      logic fb;
      fb = c[SIG_W-1] ^ bit_i;
      return {c[SIG_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

   // ready seen in the same cycle the start pulse is presented is stale from the previous operation
   assign rdy_ok   = dut_ready && !dut_start_q;
   assign pass_now = (crc_q == golden) && !timeout_q;

   always_comb begin
      state_d     = state_q;
      tmode_d     = mode_tgl ? ~tmode_q : tmode_q;
      dut_rst_d   = 1'b0;
      dut_start_d = 1'b0;
      dut_a_d     = dut_a_q;
      dut_b_d     = dut_b_q;
      result_d    = result_q;
      sig_d       = sig_q;
      run_cnt_d   = run_cnt_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      lfsr1_d     = lfsr1_q;
      lfsr2_d     = lfsr2_q;
      crc_d       = crc_q;
      iter_d      = iter_q;
      bidx_d      = bidx_q;
      wd_d        = wd_q;
      y_d         = y_q;
      case (state_q)
         IDLE:   state_d = tmode_q ? T_INIT : N_LOAD;
         N_LOAD: begin
            dut_a_d     = a;
            dut_b_d     = b;
            dut_start_d = 1'b1;
            wd_d        = '0;
            state_d     = N_WAIT;
         end
         N_WAIT: begin
            if (rdy_ok) begin
               state_d = N_OUT;
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         N_OUT: begin
            result_d = dut_y;
            state_d  = IDLE;
         end
         T_INIT: begin
            lfsr1_d = (a == '0) ? {{(W-1){1'b0}}, 1'b1} : a;
            lfsr2_d = (b == '0) ? {{(W-1){1'b0}}, 1'b1} : b;
            crc_d   = '0;
            iter_d  = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            state_d = T_STEP;
         end
         T_STEP: begin
            lfsr1_d   = lfsr_step(lfsr1_q);
            lfsr2_d   = lfsr_step(lfsr2_q);
            dut_rst_d = 1'b1;
            state_d   = T_LOAD;
         end
         T_LOAD: begin
            dut_a_d     = lfsr1_q;
            dut_b_d     = lfsr2_q;
            dut_start_d = 1'b1;
            wd_d        = '0;
            state_d     = T_WAIT;
         end
         T_WAIT: begin
            if (rdy_ok) begin
               y_d     = dut_y;
               bidx_d  = '0;
               state_d = T_SHIFT;
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               fail_d    = 1'b1;
               dut_rst_d = 1'b1;
               state_d   = T_DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         T_SHIFT: begin
            crc_d = crc_step(crc_q, y_q[0]);
            y_d   = y_q >> 1;
            if (bidx_q == BIT_LAST) state_d = T_NEXT;
            else                    bidx_d  = bidx_q + 1'b1;
         end
         T_NEXT: begin
            iter_d  = iter_q + 16'd1;
            state_d = (iter_q == ITER_LAST) ? T_DONE : T_STEP;
         end
         T_DONE: begin
            if (done_ent_q) begin
               sig_d     = crc_q;
               pass_d    = pass_now;
               fail_d    = !pass_now;
               run_cnt_d = run_cnt_q + 8'd1;
            end
            if (!tmode_q) begin
               dut_rst_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      done_ent_d = (state_d == T_DONE) && (state_q != T_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tmode_q     <= 1'b0;
         dut_rst_q   <= 1'b1;
         dut_start_q <= 1'b0;
         dut_a_q     <= '0;
         dut_b_q     <= '0;
         result_q    <= '0;
         sig_q       <= '0;
         run_cnt_q   <= '0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         lfsr1_q     <= '0;
         lfsr2_q     <= '0;
         crc_q       <= '0;
         iter_q      <= '0;
         bidx_q      <= '0;
         wd_q        <= '0;
         y_q         <= '0;
         done_ent_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmode_q     <= tmode_d;
         dut_rst_q   <= dut_rst_d;
         dut_start_q <= dut_start_d;
         dut_a_q     <= dut_a_d;
         dut_b_q     <= dut_b_d;
         result_q    <= result_d;
         sig_q       <= sig_d;
         run_cnt_q   <= run_cnt_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         lfsr1_q     <= lfsr1_d;
         lfsr2_q     <= lfsr2_d;
         crc_q       <= crc_d;
         iter_q      <= iter_d;
         bidx_q      <= bidx_d;
         wd_q        <= wd_d;
         y_q         <= y_d;
         done_ent_q  <= done_ent_d;
      end
   end

   assign dut_rst   = dut_rst_q;
   assign dut_start = dut_start_q;
   assign dut_a     = dut_a_q;
   assign dut_b     = dut_b_q;
   assign result    = result_q;
   assign sig       = sig_q;
   assign run_cnt   = run_cnt_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = timeout_q;
   assign busy      = state_q inside {T_INIT, T_STEP, T_LOAD, T_WAIT, T_SHIFT, T_NEXT};

endmodule

// File: doc/bist_engine.md
BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 Parameters (name, default, meaning): W 8 operand width; RW 12 DUT result width; SIG_W 8 signature width; ITER 256 vectors per test run (2..65536); LFSR_POLY 8'hB8 Galois LFSR taps (W bits); CRC_POLY 8'h07 CRC polynomial (SIG_W bits); TIMEOUT 1023 max wait cycles for dut_ready.
REQ-002 Ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high; mode_tgl in 1 debounced one-cycle pulse, toggles test mode; a in W operand A / LFSR1 seed; b in W operand B / LFSR2 seed; golden in SIG_W expected signature.
REQ-003 Ports (continued): dut_rst out 1; dut_start out 1 one-cycle start pulse; dut_a out W; dut_b out W; dut_y in RW DUT result; dut_ready in 1 result valid (level).
REQ-004 Ports (continued): result out RW last normal-mode result; sig out SIG_W signature; run_cnt out 8 completed test runs; busy out 1; pass out 1; fail out 1; timeout out 1 sticky watchdog flag.

Function
REQ-005 test_mode register SHALL toggle on every mode_tgl pulse; sampled only in IDLE; a toggle mid-run SHALL not abort the run.
REQ-006 FSM states: IDLE, N_LOAD, N_WAIT, N_OUT, T_INIT, T_STEP, T_LOAD, T_WAIT, T_SHIFT, T_NEXT, T_DONE.
REQ-007 IDLE: dut_rst<=0; test_mode=0 -> N_LOAD; test_mode=1 -> T_INIT.
REQ-008 N_LOAD: dut_a<=a, dut_b<=b, dut_start<=1 for exactly one cycle -> N_WAIT.
REQ-009 N_WAIT: when dut_ready=1 -> N_OUT; N_OUT: result<=dut_y -> IDLE.
REQ-010 T_INIT: LFSR1<=a, LFSR2<=b, zero seed replaced by 1; CRC<=0; iteration counter<=0; pass<=0, fail<=0, busy<=1 -> T_STEP.
REQ-011 T_STEP: both LFSRs advance one step: r<=(r>>1)^(r[0]?LFSR_POLY:0); dut_rst<=1 for one cycle -> T_LOAD.
REQ-012 T_LOAD: dut_a<=LFSR1, dut_b<=LFSR2, dut_start one-cycle pulse -> T_WAIT.
REQ-013 T_WAIT: dut_ready=1 -> T_SHIFT with bit index 0; watchdog counts wait cycles; count reaching TIMEOUT -> timeout<=1, fail<=1, dut_rst<=1 -> T_DONE.
REQ-014 N_WAIT SHALL apply the same watchdog; on expiry timeout<=1, result unchanged -> IDLE.
REQ-015 T_SHIFT: one bit per cycle, LSB first, dut_y[0..RW-1]; fb=crc[SIG_W-1]^bit; crc<={crc[SIG_W-2:0],0}^(fb?CRC_POLY:0); after bit RW-1 -> T_NEXT (exactly RW cycles).
REQ-016 T_NEXT: iteration counter +1; counter==ITER-1 before increment -> T_DONE, else -> T_STEP.
REQ-017 T_DONE (entry cycle): sig<=crc; pass<=(crc==golden)&~timeout; fail<=~pass; run_cnt<=run_cnt+1 (wraps 255->0); busy<=0.
REQ-018 T_DONE SHALL hold until test_mode=0, then assert dut_rst one cycle -> IDLE; pass/fail/sig hold until next T_INIT or rst.
REQ-019 busy=1 in every T_* state except T_DONE; 0 in normal-mode states.
REQ-020 Signature over a run SHALL depend only on a, b, DUT function and parameters (deterministic, repeatable).
REQ-021 dut_start SHALL never be asserted while dut_rst=1.

Reset
REQ-022 rst=1 in any state, including mid-run: state<=IDLE, test_mode<=0, dut_rst<=1, dut_start<=0, dut_a/dut_b<=0, result<=0, sig<=0, run_cnt<=0, busy<=0, pass<=0, fail<=0, timeout<=0, LFSRs/CRC/counters<=0; mode_tgl during rst ignored.

Verification
REQ-023 Normal: a=0x10, b=0x04, DUT model dut_y=a*b after 5 cycles -> one dut_start pulse, result=0x040, busy=0.
REQ-024 LFSR seed: test mode, a=0x01, b=0x00 -> first vector dut_a=0xB8, dut_b=0xB8 (zero seed replaced by 1).
REQ-025 CRC: ITER=2 build, DUT returns 0x001 then 0x000 -> 24 shift cycles, sig matches bit-serial model; golden equal -> pass=1, fail=0, run_cnt=1; golden^1 -> pass=0, fail=1.
REQ-026 Timeout: dut_ready held 0 in test mode -> after 1023 wait cycles timeout=1, fail=1, pass=0, T_DONE reached.
REQ-027 Reset mid-run: rst pulsed during T_SHIFT -> all outputs at reset values next cycle; restarted run yields identical sig to an uninterrupted run.
REQ-028 Mode toggle mid-run: mode_tgl in T_WAIT -> run completes, pass/fail valid, then return to IDLE and normal operation.
